sipo_deframer: RTL

//   Serial-to-parallel receive stage that consumes the MSB-first bit stream produced by
//   the shift-register serializer. It aligns on a frame_start marker and assembles WIDTH

---
 rtl/sipo_deframer.sv | 117 +++++++++++
 1 files changed

// File: rtl/sipo_deframer.sv
// MSB-first serial receive stage: aligns on frame_start, assembles WIDTH data bits
// (plus an optional even-parity bit) and hands words out through a one-entry buffer.
module sipo_deframer #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;

  logic             start;
  logic             bit_take;
  logic             last_data;
  logic             commit;
  logic [WIDTH-1:0] commit_data;
  logic             commit_perr;
  logic             buf_free;

  // A frame_start bit always wins: it restarts assembly from any state.
  assign start     = serial_valid & frame_start;
  assign bit_take  = serial_valid & ~frame_start;
  assign last_data = (state == DATA) && bit_take && (cnt == CW'(WIDTH - 1));
  assign buf_free  = ~out_valid | out_ready;

  // Without parity the word completes with the bit being sampled now; with parity
  // the data is already in shreg and the current bit is the parity bit.
  assign commit      = PARITY_EN ? ((state == PAR) && bit_take) : last_data;
  assign commit_data = PARITY_EN ? shreg : {shreg[WIDTH-2:0], serial_in};
  assign commit_perr = PARITY_EN ? ^{shreg, serial_in} : 1'b0;

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  // NOTE: state_nxt gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = DATA;
    end else begin
      case (state)
        DATA: if (last_data) state_nxt = PARITY_EN ? PAR : IDLE;
        PAR:  if (bit_take)  state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Frame assembly keeps running even when the holding buffer is full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (start) begin
      shreg <= {{(WIDTH-1){1'b0}}, serial_in};
      cnt   <= CW'(1);
    end else if ((state == DATA) && bit_take) begin
      shreg <= {shreg[WIDTH-2:0], serial_in};
      cnt   <= cnt + CW'(1);
    end
  end

  // Holding buffer: a commit into a free slot replaces any word being accepted now.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
    end else if (commit && buf_free) begin
      out_data   <= commit_data;
      out_valid  <= 1'b1;
      parity_err <= commit_perr;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               overrun <= 1'b0;
    else if (commit && !buf_free) overrun <= 1'b1;
    else if (overrun_clr)       overrun <= 1'b0;
  end

endmodule
